// File: rtl/delay_line_mc_pkg.sv
// ---------------------------------------------------------------------------
// dsp_delay_pkg
// Shared constants and helpers for the multi-channel tapped delay line.
//   f_depth_w : width needed to hold a depth/count value 0..max_stages
//   f_tap_lsb : bit offset of (stage, channel) inside the flattened tap bus
// ---------------------------------------------------------------------------
package dsp_delay_pkg;

    // Depth and fill count must represent 0..max_stages inclusive, so the
    // saturation value itself always fits in the counter.
    function automatic int f_depth_w(input int max_stages);
        return (max_stages < 1) ? 1 : $clog2(max_stages + 1);
    endfunction

    // Stage numbering starts at 1 (stage 1 is the newest sample); channels
    // of one stage sit next to each other in the flattened bus.
    function automatic int f_tap_lsb(input int stage, input int channel,
                                     input int nr_channels, input int data_width);
        return ((stage - 1) * nr_channels + channel) * data_width;
    endfunction

endpackage

// File: rtl/delay_line_mc_if.sv
// ---------------------------------------------------------------------------
// delay_line_mc_if
// Bundles the control, data and status signals of the delay line.
//   i_ena        : shift enable
//   i_flush      : synchronous clear of stages and fill counter
//   i_depth      : requested output depth (saturated inside the design)
//   i_data       : newest sample, one slice per channel
//   o_data       : per-channel sample at the effective depth
//   o_taps       : every stage, every channel
//   o_fill_cnt   : accepted shifts since reset/flush, saturating
//   o_shift_done : fill count has reached the effective depth
// master drives the inputs (stimulus side), slave is the delay line.
// ---------------------------------------------------------------------------
import dsp_delay_pkg::*;

interface delay_line_mc_if #(
    parameter int gp_data_width  = 8,
    parameter int gp_nr_channels = 2,
    parameter int gp_max_stages  = 8
);
    localparam int C_DEPTH_W = f_depth_w(gp_max_stages);
    localparam int C_LANE_W  = gp_nr_channels * gp_data_width;

    logic                                i_ena;
    logic                                i_flush;
    logic [C_DEPTH_W-1:0]                i_depth;
    logic [C_LANE_W-1:0]                 i_data;
    logic [C_LANE_W-1:0]                 o_data;
    logic [gp_max_stages*C_LANE_W-1:0]   o_taps;
    logic [C_DEPTH_W-1:0]                o_fill_cnt;
    logic                                o_shift_done;

    modport master (
        output i_ena, i_flush, i_depth, i_data,
        input  o_data, o_taps, o_fill_cnt, o_shift_done
    );

    modport slave (
        input  i_ena, i_flush, i_depth, i_data,
        output o_data, o_taps, o_fill_cnt, o_shift_done
    );
endinterface

// File: rtl/delay_line_mc_stage.sv
// ---------------------------------------------------------------------------
// dl_stage
// One delay stage holding all channels of a single time slot.
//   i_clk : rising-edge clock
//   i_rst : synchronous active-high reset
//   i_clr : synchronous clear (flush), same effect as reset
//   i_ena : load i_d when high
//   i_d   : sample from the previous stage (or the line input)
//   o_q   : registered sample
// ---------------------------------------------------------------------------
module dl_stage #(
    parameter int gp_width = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_clr,
    input  logic                i_ena,
    input  logic [gp_width-1:0] i_d,
    output logic [gp_width-1:0] o_q
);
    logic [gp_width-1:0] r_q;

    // Reset and flush both clear; a flush wins over a simultaneous enable so
    // the sample presented during a flush is discarded.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_q <= '0;
        end else if (i_ena) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/delay_line_mc.sv
// ---------------------------------------------------------------------------
// delay_line_mc
// Multi-channel tapped delay line with runtime-selectable output depth.
//   i_clk : rising-edge clock
//   i_rst : synchronous active-high reset
//   bus   : delay_line_mc_if.slave (ena, flush, depth, data in;
//           data at depth, all taps, fill count, done flag out)
// Depth 0 is a combinational bypass; depths above gp_max_stages saturate.
// ---------------------------------------------------------------------------
import dsp_delay_pkg::*;

module delay_line_mc #(
    parameter int gp_data_width  = 8,
    parameter int gp_nr_channels = 2,
    parameter int gp_max_stages  = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    delay_line_mc_if.slave      bus
);
    localparam int C_DEPTH_W = f_depth_w(gp_max_stages);
    localparam int C_LANE_W  = gp_nr_channels * gp_data_width;
    localparam logic [C_DEPTH_W-1:0] C_MAX = C_DEPTH_W'(gp_max_stages);

    // Index 0 is the line input, index k the output of stage k.
    logic [C_LANE_W-1:0]  w_stage [0:gp_max_stages];
    logic [C_DEPTH_W-1:0] w_depth_eff;
    logic [C_LANE_W-1:0]  w_data;
    logic [C_DEPTH_W-1:0] r_fill_cnt;

    assign w_stage[0] = bus.i_data;

    genvar k;
    generate
        for (k = 1; k <= gp_max_stages; k++) begin : g_stage
            dl_stage #(
                .gp_width (C_LANE_W)
            ) u_stage (
                .i_clk (i_clk),
                .i_rst (i_rst),
                .i_clr (bus.i_flush),
                .i_ena (bus.i_ena),
                .i_d   (w_stage[k-1]),
                .o_q   (w_stage[k])
            );
            assign bus.o_taps[f_tap_lsb(k, 0, gp_nr_channels, gp_data_width) +: C_LANE_W] = w_stage[k];
        end
    endgenerate

    // Fill counter tracks accepted shifts and sticks at the physical depth,
    // so it never wraps back below a valid depth.
    always_ff @(posedge i_clk) begin
        if (i_rst || bus.i_flush) begin
            r_fill_cnt <= '0;
        end else if (bus.i_ena && (r_fill_cnt != C_MAX)) begin
            r_fill_cnt <= r_fill_cnt + C_DEPTH_W'(1);
        end
    end

    // Requested depth clipped to the physical line length; 0 passes through.
    always_comb begin
        w_depth_eff = bus.i_depth;
        if (bus.i_depth > C_MAX) begin
            w_depth_eff = C_MAX;
        end
    end

    // Output mux: depth 0 selects the line input itself (zero latency).
    always_comb begin
        w_data = bus.i_data;
        for (int s = 1; s <= gp_max_stages; s++) begin
            if (int'(w_depth_eff) == s) begin
                w_data = w_stage[s];
            end
        end
    end

    assign bus.o_data       = w_data;
    assign bus.o_fill_cnt   = r_fill_cnt;
    assign bus.o_shift_done = (r_fill_cnt >= w_depth_eff);
endmodule

// File: tb/tb_delay_line_mc.sv
// ---------------------------------------------------------------------------
// tb_delay_line_mc
// Scoreboard bench for delay_line_mc (W=8, CH=2, MAX=8). The stimulus side
// keeps a reference history of accepted samples and queues the expected
// outputs for every driven cycle; a monitor pops and compares on negedge.
// ---------------------------------------------------------------------------
module tb_delay_line_mc;
    localparam int W    = 8;
    localparam int CH   = 2;
    localparam int MAX  = 8;
    localparam int DW   = 4;
    localparam int LANE = W * CH;

    typedef struct {
        logic [LANE-1:0]     data;
        logic [DW-1:0]       fill;
        logic                done;
        logic [MAX*LANE-1:0] taps;
        int                  phase;
    } exp_t;

    logic clk;
    logic rst;
    exp_t expQ [$];
    logic [LANE-1:0] hist [$];
    int checks;
    int failures;
    int phase;

    delay_line_mc_if #(.gp_data_width(W), .gp_nr_channels(CH), .gp_max_stages(MAX)) bus ();

    delay_line_mc #(
        .gp_data_width  (W),
        .gp_nr_channels (CH),
        .gp_max_stages  (MAX)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so a broken design can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL timeout phase=%0d got=running required=finished", phase);
        $fatal(1, "[TB] time limit reached");
    end

    // Drive one cycle, queue what the outputs must be during it, then let the
    // edge happen and advance the reference history the same way the line
    // is meant to behave: newest sample first, at most MAX kept.
    task automatic applyStimulus(input logic r, input logic fl, input logic en,
                                 input logic [DW-1:0] depth, input logic [LANE-1:0] din,
                                 input bit chk);
        exp_t e;
        int   d;
        rst         = r;
        bus.i_flush = fl;
        bus.i_ena   = en;
        bus.i_depth = depth;
        bus.i_data  = din;
        d = (int'(depth) > MAX) ? MAX : int'(depth);
        if (d == 0)                 e.data = din;
        else if (d <= hist.size())  e.data = hist[d-1];
        else                        e.data = '0;
        e.fill = DW'(hist.size());
        e.done = (hist.size() >= d);
        e.taps = '0;
        for (int k = 1; k <= MAX; k++) begin
            if (k <= hist.size()) e.taps[(k-1)*LANE +: LANE] = hist[k-1];
        end
        e.phase = phase;
        if (chk) expQ.push_back(e);
        @(negedge clk);
        @(posedge clk);
        if (r || fl) begin
            hist.delete();
        end else if (en) begin
            hist.push_front(din);
            if (hist.size() > MAX) void'(hist.pop_back());
        end
        #1;
    endtask

    // Compare the live outputs against the oldest queued expectation.
    task automatic checkOutput();
        exp_t e;
        e = expQ.pop_front();
        checks++;
        if (bus.o_data !== e.data) begin
            failures++;
            $display("[TB] FAIL o_data phase=%0d got=%h required=%h", e.phase, bus.o_data, e.data);
        end
        checks++;
        if (bus.o_fill_cnt !== e.fill) begin
            failures++;
            $display("[TB] FAIL o_fill_cnt phase=%0d got=%0d required=%0d", e.phase, bus.o_fill_cnt, e.fill);
        end
        checks++;
        if (bus.o_shift_done !== e.done) begin
            failures++;
            $display("[TB] FAIL o_shift_done phase=%0d got=%b required=%b", e.phase, bus.o_shift_done, e.done);
        end
        checks++;
        if (bus.o_taps !== e.taps) begin
            failures++;
            $display("[TB] FAIL o_taps phase=%0d got=%h required=%h", e.phase, bus.o_taps, e.taps);
        end
    endtask

    // Monitor: decoupled from stimulus, consumes one expectation per cycle.
    always @(negedge clk) begin
        if (expQ.size() > 0) checkOutput();
    end

    function automatic logic [LANE-1:0] lanePair(input int n);
        return {8'(8'h80 + n), 8'(n)};
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        phase    = 0;
        rst = 1'b1;
        bus.i_ena = 1'b0; bus.i_flush = 1'b0; bus.i_depth = '0; bus.i_data = '0;

        // Initial reset: outputs undefined until the first edge, so unchecked.
        applyStimulus(1, 0, 0, 4'd4, '0, 0);

        // Bypass while reset is held: data passes straight through, done=1.
        phase = 1;
        applyStimulus(1, 0, 1, 4'd0, 16'h5AA5, 1);
        applyStimulus(1, 0, 0, 4'd0, 16'hC3A5, 1);
        applyStimulus(0, 0, 0, 4'd0, 16'h00A5, 1);

        // Fill from empty at depth 4.
        phase = 2;
        applyStimulus(1, 0, 0, 4'd4, '0, 1);
        for (int n = 1; n <= 10; n++) applyStimulus(0, 0, 1, 4'd4, lanePair(n), 1);

        // Flush with simultaneous enable at depth 2; 0x55 must be dropped.
        phase = 3;
        applyStimulus(0, 1, 1, 4'd2, 16'h5555, 1);
        applyStimulus(0, 0, 0, 4'd2, 16'h5555, 1);

        // Gapped enable at depth 3.
        phase = 4;
        applyStimulus(0, 0, 1, 4'd3, 16'h0011, 1);
        applyStimulus(0, 0, 0, 4'd3, 16'hDEAD, 1);
        applyStimulus(0, 0, 1, 4'd3, 16'h0022, 1);
        applyStimulus(0, 0, 0, 4'd3, 16'hBEEF, 1);
        applyStimulus(0, 0, 1, 4'd3, 16'h0033, 1);
        applyStimulus(0, 0, 0, 4'd3, 16'h0000, 1);

        // Full line holding 1..8, then depth changes and saturation.
        phase = 5;
        applyStimulus(0, 1, 0, 4'd8, '0, 1);
        for (int n = 1; n <= 8; n++) applyStimulus(0, 0, 1, 4'd8, 16'(n), 1);
        applyStimulus(0, 0, 0, 4'd2, '0, 1);
        applyStimulus(0, 0, 0, 4'd15, '0, 1);
        applyStimulus(0, 0, 0, 4'd9, '0, 1);
        for (int n = 0; n < 20; n++) applyStimulus(0, 0, 1, 4'd15, 16'($urandom), 1);

        // Reset mid-operation at depth 4, then refill.
        phase = 6;
        applyStimulus(0, 1, 0, 4'd4, '0, 1);
        for (int n = 1; n <= 5; n++) applyStimulus(0, 0, 1, 4'd4, lanePair(n), 1);
        applyStimulus(1, 0, 1, 4'd4, 16'h7777, 1);
        for (int n = 1; n <= 5; n++) applyStimulus(0, 0, 1, 4'd4, lanePair(n + 16), 1);

        // Randomised traffic across all controls and depths.
        phase = 7;
        for (int n = 0; n < 300; n++) begin
            applyStimulus(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                          4'($urandom_range(0, 15)),
                          16'($urandom), 1);
        end

        // Let the monitor drain; anything left over is a lost comparison.
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain got=%0d required=0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
